// File: rtl/datamem_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of the single-ported data memory.
// Latency: write strobe 1 cycle after grant; read data returned READ_LAT+2 cycles after grant.
// Backpressure: one access in flight; requesters hold req until gnt, grants only issued in IDLE.
module datamem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int READ_LAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  // port 0: CPU load/store stage
  input  logic          req0,
  input  logic          we0,
  input  logic          sb0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  // port 1: loader/debug port
  input  logic          req1,
  input  logic          we1,
  input  logic          sb1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  // DataMem side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic          mem_str_byte,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  // Counter start value for the read wait; READ_LAT is limited to 0..3.
  localparam logic [1:0] LAT_INIT = 2'(READ_LAT);

  state_t          state_q, state_d;
  logic            prio_q;        // 0: port 0 wins a tie, 1: port 1 wins
  logic [1:0]      cnt_q;         // remaining read-wait cycles
  logic            port_q;        // port that owns the access in flight
  logic            we_q;
  logic            sb_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata0_q, rdata1_q;
  logic            rv0_q, rv1_q;

  logic            gnt0_c, gnt1_c;
  logic            rd_c, wr_c, sb_c;
  logic            capture;
  logic            busy;

  // Next-state, grant and memory strobe decode.
  always_comb begin
    state_d = state_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    sb_c    = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A lone request wins outright; on a tie the priority pointer decides.
        if (req0 && (!req1 || !prio_q)) begin
          gnt0_c = 1'b1;
        end else if (req1) begin
          gnt1_c = 1'b1;
        end
        if (gnt0_c || gnt1_c) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          wr_c    = 1'b1;
          sb_c    = sb_q;
          state_d = S_IDLE;
        end else begin
          rd_c = 1'b1;
          if (READ_LAT == 0) begin
            capture = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        // Address is still held from the latch; keep the read strobe up until data is due.
        rd_c = 1'b1;
        if (cnt_q == 2'd1) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the granted request and move the priority pointer to the other port.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      sb_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (gnt0_c) begin
      prio_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= we0;
      sb_q    <= sb0;
      addr_q  <= addr0;
      wdata_q <= wdata0;
    end else if (gnt1_c) begin
      prio_q  <= 1'b0;
      port_q  <= 1'b1;
      we_q    <= we1;
      sb_q    <= sb1;
      addr_q  <= addr1;
      wdata_q <= wdata1;
    end
  end

  // Read wait counter: loaded when a read leaves ACCESS, counts down through RDWAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else if (state_q == S_ACCESS) begin
      cnt_q <= LAT_INIT;
    end else if (state_q == S_RDWAIT) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  // Capture read data for the owning port and raise its one-cycle valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
    end else begin
      rv0_q <= capture && !port_q;
      rv1_q <= capture && port_q;
      if (capture && !port_q) begin
        rdata0_q <= mem_rdata;
      end
      if (capture && port_q) begin
        rdata1_q <= mem_rdata;
      end
    end
  end

  // Outputs are forced low while reset is asserted so nothing leaks out of an aborted access.
  assign busy         = (state_q != S_IDLE) && !rst;
  assign gnt0         = gnt0_c && !rst;
  assign gnt1         = gnt1_c && !rst;
  assign mem_read     = rd_c && !rst;
  assign mem_write    = wr_c && !rst;
  assign mem_str_byte = sb_c && !rst;
  assign mem_addr     = busy ? addr_q : '0;
  assign mem_wdata    = busy ? wdata_q : '0;
  assign rvalid0      = rv0_q && !rst;
  assign rvalid1      = rv1_q && !rst;
  assign rdata0       = rst ? '0 : rdata0_q;
  assign rdata1       = rst ? '0 : rdata1_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter: three instances at different read latencies.
// Each instance has its own behavioural DataMem and a transaction-level reference model.
// Requests are queued per port and held until granted, as the requester protocol demands.
module tb_datamem_arbiter;

  localparam int NI = 3;
  localparam int LATS [NI] = '{0, 2, 3};

  typedef struct packed {
    logic        we;
    logic        sb;
    logic [15:0] addr;
    logic [15:0] wdata;
  } rq_t;

  logic clk = 1'b0;
  logic rst;

  logic        req0 [NI], we0 [NI], sb0 [NI], req1 [NI], we1 [NI], sb1 [NI];
  logic [15:0] addr0 [NI], wdata0 [NI], addr1 [NI], wdata1 [NI];
  logic        gnt0 [NI], gnt1 [NI], rvalid0 [NI], rvalid1 [NI];
  logic [15:0] rdata0 [NI], rdata1 [NI];
  logic [15:0] mem_addr [NI], mem_wdata [NI], mem_rdata [NI];
  logic        mem_read [NI], mem_write [NI], mem_str_byte [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    logic [15:0] env_mem [256];
    int          rd_run;

    datamem_arbiter #(
      .AW(16), .DW(16), .READ_LAT(LATS[gi])
    ) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0[gi]), .we0(we0[gi]), .sb0(sb0[gi]), .addr0(addr0[gi]), .wdata0(wdata0[gi]),
      .gnt0(gnt0[gi]), .rvalid0(rvalid0[gi]), .rdata0(rdata0[gi]),
      .req1(req1[gi]), .we1(we1[gi]), .sb1(sb1[gi]), .addr1(addr1[gi]), .wdata1(wdata1[gi]),
      .gnt1(gnt1[gi]), .rvalid1(rvalid1[gi]), .rdata1(rdata1[gi]),
      .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]), .mem_read(mem_read[gi]),
      .mem_write(mem_write[gi]), .mem_str_byte(mem_str_byte[gi]), .mem_rdata(mem_rdata[gi])
    );

    // Behavioural DataMem: byte store replaces only the low byte; read data is
    // only meaningful once mem_read has been held for LATS[gi] prior cycles.
    always @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < 256; k++) env_mem[k] <= '0;
        rd_run <= 0;
      end else begin
        if (mem_write[gi]) begin
          if (mem_str_byte[gi]) env_mem[mem_addr[gi][7:0]][7:0] <= mem_wdata[gi][7:0];
          else                  env_mem[mem_addr[gi][7:0]]      <= mem_wdata[gi];
        end
        rd_run <= mem_read[gi] ? rd_run + 1 : 0;
      end
    end

    assign mem_rdata[gi] = (mem_read[gi] && rd_run >= LATS[gi]) ?
                           env_mem[mem_addr[gi][7:0]] : 16'hDEAD;
  end

  // Stimulus queues: index 2*i is port 0 of instance i, 2*i+1 is port 1.
  rq_t pq [NI*2][$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic rst_want;
  logic rand_on;

  // Reference model state (transaction level).
  logic        prio_m   [NI];
  int          free_m   [NI];
  logic        op_act   [NI];
  int          op_start [NI];
  logic        op_port  [NI];
  rq_t         op_rq    [NI];
  logic [15:0] op_rd    [NI];
  logic [15:0] exp_rd   [NI][2];
  logic [15:0] mmem     [NI][256];

  task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] cyc %0d: got %0h, expected %0h", tag, inst, cyc, got, exp);
    end
  endtask

  function automatic rq_t mk(input logic we, input logic sb, input logic [15:0] a, input logic [15:0] d);
    rq_t r;
    r.we = we; r.sb = sb; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic rq_t rnd_rq();
    return mk(1'($urandom % 2), 1'($urandom % 2), 16'($urandom_range(0, 15)), 16'($urandom));
  endfunction

  function automatic bit all_idle();
    bit idle = 1'b1;
    for (int i = 0; i < NI; i++) begin
      if (pq[2*i].size() != 0 || pq[2*i+1].size() != 0 || op_act[i]) idle = 1'b0;
    end
    return idle;
  endfunction

  task automatic drive();
    rst = rst_want;
    for (int i = 0; i < NI; i++) begin
      rq_t h0, h1;
      h0 = '0;
      h1 = '0;
      if (pq[2*i].size() != 0)   h0 = pq[2*i][0];
      if (pq[2*i+1].size() != 0) h1 = pq[2*i+1][0];
      req0[i] = (pq[2*i].size() != 0);
      req1[i] = (pq[2*i+1].size() != 0);
      we0[i] = h0.we; sb0[i] = h0.sb; addr0[i] = h0.addr; wdata0[i] = h0.wdata;
      we1[i] = h1.we; sb1[i] = h1.sb; addr1[i] = h1.addr; wdata1[i] = h1.wdata;
    end
  endtask

  // Compare every output of every instance with the model, then advance the model.
  task automatic check_cycle();
    for (int i = 0; i < NI; i++) begin
      int   lat;
      logic eg0, eg1, er, ew, erv0, erv1, p;
      rq_t  r;
      lat = LATS[i];
      if (rst) begin
        chk("rst_gnt0", i, gnt0[i], 0);
        chk("rst_gnt1", i, gnt1[i], 0);
        chk("rst_mem_read", i, mem_read[i], 0);
        chk("rst_mem_write", i, mem_write[i], 0);
        chk("rst_mem_sb", i, mem_str_byte[i], 0);
        chk("rst_mem_addr", i, mem_addr[i], 0);
        chk("rst_mem_wdata", i, mem_wdata[i], 0);
        chk("rst_rvalid0", i, rvalid0[i], 0);
        chk("rst_rvalid1", i, rvalid1[i], 0);
        chk("rst_rdata0", i, rdata0[i], 0);
        chk("rst_rdata1", i, rdata1[i], 0);
        prio_m[i] = 1'b0;
        free_m[i] = cyc + 1;
        op_act[i] = 1'b0;
        exp_rd[i][0] = '0;
        exp_rd[i][1] = '0;
        for (int k = 0; k < 256; k++) mmem[i][k] = '0;
      end else begin
        eg0 = 0; eg1 = 0; er = 0; ew = 0; erv0 = 0; erv1 = 0;
        if (op_act[i]) begin
          if (op_rq[i].we) begin
            ew = (cyc == op_start[i]);
            if (cyc >= op_start[i]) op_act[i] = 1'b0;
          end else begin
            er = (cyc >= op_start[i]) && (cyc <= op_start[i] + lat);
            if (cyc == op_start[i] + lat + 1) begin
              if (op_port[i]) erv1 = 1'b1; else erv0 = 1'b1;
              exp_rd[i][op_port[i]] = op_rd[i];
              op_act[i] = 1'b0;
            end
          end
        end
        if (cyc >= free_m[i]) begin
          if (req0[i] && (!req1[i] || !prio_m[i])) eg0 = 1'b1;
          else if (req1[i])                        eg1 = 1'b1;
        end
        chk("gnt0", i, gnt0[i], eg0);
        chk("gnt1", i, gnt1[i], eg1);
        chk("mem_read", i, mem_read[i], er);
        chk("mem_write", i, mem_write[i], ew);
        if (er || ew) chk("mem_addr", i, mem_addr[i], op_rq[i].addr);
        if (ew) chk("mem_wdata", i, mem_wdata[i], op_rq[i].wdata);
        if (ew) chk("mem_sb_wr", i, mem_str_byte[i], op_rq[i].sb);
        if (er) chk("mem_sb_rd", i, mem_str_byte[i], 0);
        chk("rvalid0", i, rvalid0[i], erv0);
        chk("rvalid1", i, rvalid1[i], erv1);
        chk("rdata0", i, rdata0[i], exp_rd[i][0]);
        chk("rdata1", i, rdata1[i], exp_rd[i][1]);
        if (eg0 || eg1) begin
          p = eg1;
          r = p ? mk(we1[i], sb1[i], addr1[i], wdata1[i]) : mk(we0[i], sb0[i], addr0[i], wdata0[i]);
          op_act[i]   = 1'b1;
          op_start[i] = cyc + 1;
          op_port[i]  = p;
          op_rq[i]    = r;
          prio_m[i]   = !p;
          if (r.we) begin
            free_m[i] = cyc + 2;
            if (r.sb) mmem[i][r.addr[7:0]][7:0] = r.wdata[7:0];
            else      mmem[i][r.addr[7:0]]      = r.wdata;
          end else begin
            op_rd[i]  = mmem[i][r.addr[7:0]];
            free_m[i] = cyc + 2 + lat;
          end
        end
      end
      // Requester side: retire on grant, occasionally withdraw, refill in random mode.
      for (int pp = 0; pp < 2; pp++) begin
        logic g, rq, withdrew;
        int   qi;
        qi = 2*i + pp;
        g  = (pp == 0) ? gnt0[i] : gnt1[i];
        rq = (pp == 0) ? req0[i] : req1[i];
        withdrew = 1'b0;
        if (g === 1'b1) begin
          void'(pq[qi].pop_front());
        end else if (rand_on && rq && !rst && ($urandom % 32) == 0) begin
          void'(pq[qi].pop_front());
          withdrew = 1'b1;
        end
        if (rand_on && !withdrew && pq[qi].size() == 0 && ($urandom % 4) != 0)
          pq[qi].push_back(rnd_rq());
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_cycle();
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !all_idle()) begin
      cycle();
      n++;
    end
    chk("idle_timeout", 0, all_idle(), 1);
  endtask

  initial begin
    rst_want = 1'b1;
    rand_on  = 1'b0;
    drive();
    repeat (2) cycle();
    rst_want = 1'b0;

    // Contended write/read sequence on address 0004, including a byte store.
    for (int i = 0; i < NI; i++) begin
      pq[2*i].push_back(mk(1'b1, 1'b0, 16'h0004, 16'hABCD));
      pq[2*i].push_back(mk(1'b1, 1'b1, 16'h0004, 16'h1234));
      pq[2*i].push_back(mk(1'b0, 1'b0, 16'h0004, 16'h0000));
      pq[2*i+1].push_back(mk(1'b0, 1'b0, 16'h0004, 16'h0000));
      pq[2*i+1].push_back(mk(1'b0, 1'b0, 16'h0004, 16'h0000));
    end
    cycle();
    for (int i = 0; i < NI; i++) begin
      chk("first_gnt0", i, gnt0[i], 1);
      chk("first_gnt1", i, gnt1[i], 0);
    end
    run_until_idle(200);
    for (int i = 0; i < NI; i++) begin
      chk("byte_store_rd1", i, rdata1[i], 16'hAB34);
      chk("byte_store_rd0", i, rdata0[i], 16'hAB34);
    end

    // Reset in the middle of a port 0 read; port 1 must not win the first grant afterwards.
    for (int i = 0; i < NI; i++) pq[2*i].push_back(mk(1'b0, 1'b0, 16'h0004, 16'h0000));
    cycle();
    for (int i = 0; i < NI; i++) chk("abort_rd_gnt0", i, gnt0[i], 1);
    cycle();
    for (int i = 0; i < NI; i++) begin
      pq[2*i].push_back(mk(1'b1, 1'b0, 16'h0004, 16'h5A5A));
      pq[2*i+1].push_back(mk(1'b0, 1'b0, 16'h0004, 16'h0000));
    end
    rst_want = 1'b1;
    cycle();
    rst_want = 1'b0;
    cycle();
    for (int i = 0; i < NI; i++) begin
      chk("post_rst_gnt0", i, gnt0[i], 1);
      chk("post_rst_gnt1", i, gnt1[i], 0);
      chk("post_rst_rvalid0", i, rvalid0[i], 0);
      chk("post_rst_rdata0", i, rdata0[i], 0);
    end
    run_until_idle(200);
    for (int i = 0; i < NI; i++) chk("post_rst_rd1", i, rdata1[i], 16'h5A5A);

    // Randomized traffic with withdrawals and occasional resets.
    rand_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst_want = (($urandom % 400) == 0);
      cycle();
    end
    rst_want = 1'b0;
    rand_on  = 1'b0;
    run_until_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
